// File: rtl/ppu_pkg.sv
// Shared types and timing constants for the PPU mode scheduler.
// The state encoding embeds the STAT mode in bits [1:0] so mode is a plain flop output.
package ppu_pkg;

    localparam int DOTS_PER_LINE = 456;
    localparam int OAM_DOTS      = 80;
    localparam int VISIBLE_LINES = 144;
    localparam int TOTAL_LINES   = 154;

    localparam logic [8:0] LAST_DOT        = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END_DOT     = 9'(OAM_DOTS - 1);
    localparam logic [7:0] FIRST_VBLANK_LY = 8'(VISIBLE_LINES);
    localparam logic [7:0] LAST_LY         = 8'(TOTAL_LINES - 1);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } ppu_mode_t;

    typedef enum logic [2:0] {
        ST_HBLANK = 3'b000,
        ST_VBLANK = 3'b001,
        ST_OAM    = 3'b010,
        ST_XFER   = 3'b011,
        ST_OFF    = 3'b100
    } ppu_state_t;

    function automatic ppu_mode_t state_mode(input ppu_state_t s);
        return ppu_mode_t'(s[1:0]);
    endfunction

endpackage

// File: rtl/ppu_stat_irq.sv
// LYC compare register, STAT line OR and rising-edge interrupt request.
// enable low forces the line low, so re-enabling with a source active yields a fresh pulse.
module ppu_stat_irq
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [7:0] LY,
    input  logic [7:0] LYC,
    input  logic [3:0] stat_sel,
    output logic       lyc_eq,
    output logic       stat_irq
);

    logic stat_line;
    logic stat_line_q;

    always_comb begin
        stat_line = enable && ((stat_sel[3] && lyc_eq) ||
                               (stat_sel[2] && (mode == MODE_OAM)) ||
                               (stat_sel[1] && (mode == MODE_VBLANK)) ||
                               (stat_sel[0] && (mode == MODE_HBLANK)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lyc_eq      <= 1'b0;
            stat_line_q <= 1'b0;
            stat_irq    <= 1'b0;
        end else begin
            lyc_eq      <= enable && (LY == LYC);
            stat_line_q <= stat_line;
            stat_irq    <= stat_line && !stat_line_q;
        end
    end

endmodule

// File: rtl/ppu_mode_scheduler.sv
// Per-dot PPU line/frame sequencer: walks OAM -> XFER -> HBLANK per visible line, then VBLANK.
//
//   state  | meaning
//   OFF    | lcd disabled, counters held at 0, mode reports 0
//   OAM    | mode 2, dots 0..79 of a visible line
//   XFER   | mode 3, pixel pipeline running until its done pulse
//   HBLANK | mode 0, rest of the visible line
//   VBLANK | mode 1, lines 144..153
module ppu_mode_scheduler
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic [7:0] LYC,
    input  logic [3:0] stat_sel,
    input  logic       mode3_done,
    output logic       oam_scan_start,
    output logic       mode3_start,
    output logic [1:0] mode,
    output logic [7:0] LY,
    output logic [8:0] dot_count,
    output logic       lyc_eq,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       frame_start,
    output logic       mode3_overrun
);

    ppu_state_t state;
    logic [7:0] ly_next;
    logic       done_ok;
    logic       active;

    assign ly_next = (LY == LAST_LY) ? 8'd0 : LY + 8'd1;
    // mode3_start is high only in the first XFER cycle, where a done pulse is stale
    assign done_ok = mode3_done && !mode3_start;
    assign active  = lcd_en && (state != ST_OFF);
    assign mode    = state_mode(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_OFF;
            dot_count      <= '0;
            LY             <= '0;
            oam_scan_start <= 1'b0;
            mode3_start    <= 1'b0;
            frame_start    <= 1'b0;
            vblank_irq     <= 1'b0;
            mode3_overrun  <= 1'b0;
        end else begin
            oam_scan_start <= 1'b0;
            mode3_start    <= 1'b0;
            frame_start    <= 1'b0;
            vblank_irq     <= 1'b0;
            if (!lcd_en) begin
                state         <= ST_OFF;
                dot_count     <= '0;
                LY            <= '0;
                mode3_overrun <= 1'b0;
            end else if (state == ST_OFF) begin
                state          <= ST_OAM;
                dot_count      <= '0;
                LY             <= '0;
                oam_scan_start <= 1'b1;
                frame_start    <= 1'b1;
            end else if (dot_count == LAST_DOT) begin
                // line wrap outranks a done pulse arriving on the last dot
                dot_count <= '0;
                LY        <= ly_next;
                if ((state == ST_XFER) && !done_ok)
                    mode3_overrun <= 1'b1;
                if (ly_next < FIRST_VBLANK_LY) begin
                    state          <= ST_OAM;
                    oam_scan_start <= 1'b1;
                    frame_start    <= (ly_next == 8'd0);
                end else begin
                    state      <= ST_VBLANK;
                    vblank_irq <= (ly_next == FIRST_VBLANK_LY);
                end
            end else begin
                dot_count <= dot_count + 9'd1;
                case (state)
                    ST_OAM: begin
                        if (dot_count == OAM_END_DOT) begin
                            state       <= ST_XFER;
                            mode3_start <= 1'b1;
                        end
                    end
                    ST_XFER: begin
                        if (done_ok)
                            state <= ST_HBLANK;
                    end
                    default: ;
                endcase
            end
        end
    end

    ppu_stat_irq u_stat_irq (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (active),
        .mode     (mode),
        .LY       (LY),
        .LYC      (LYC),
        .stat_sel (stat_sel),
        .lyc_eq   (lyc_eq),
        .stat_irq (stat_irq)
    );

endmodule
